// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall/flush sequencer for the 5-stage core.
// Times multi-cycle EX ops and redirects the PC on committed exceptions.
module pipe_ctrl #(
   parameter int MC_CNT_W = 6,
   parameter int PC_W     = 32,
   parameter int PERF_W   = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                stallreq_id,
   input  logic                stallreq_ex,
   input  logic                ex_mc_start,
   input  logic [MC_CNT_W-1:0] ex_mc_len,
   input  logic                excp_valid,
   input  logic [PC_W-1:0]     excp_handler,
   output logic [5:0]          stall,
   output logic                flush,
   output logic [PC_W-1:0]     new_pc,
   output logic                ex_mc_busy,
   output logic                ex_mc_done,
   output logic [PERF_W-1:0]   perf_stall_cnt
);
   typedef enum logic [1:0] {IDLE, MULTI, FLUSH} state_t;
   state_t              r_state;
   logic [MC_CNT_W-1:0] r_cnt;
   logic                r_flush;
   logic [PC_W-1:0]     r_new_pc;
   logic [PERF_W-1:0]   r_perf;
   logic [5:0]          w_req;
   logic [5:0]          w_stall;
   logic                w_done;
   assign w_req = stallreq_ex ? 6'b001111 : stallreq_id ? 6'b000111 : 6'b000000;
   // exceptions and reset override every hold request
   always_comb begin
      w_stall = '0;
      w_done  = 1'b0;
      if (!rst && !excp_valid) begin
         case (r_state)
            IDLE: begin
               w_stall = ex_mc_start ? (ex_mc_len != '0 ? 6'b001111 : 6'b000000) : w_req;
               w_done  = ex_mc_start && ex_mc_len == '0;
            end
            MULTI: begin
               w_stall = r_cnt > MC_CNT_W'(1) ? 6'b001111 : w_req;
               w_done  = r_cnt <= MC_CNT_W'(1);
            end
            default: ;
         endcase
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_flush  <= 1'b0;
         r_new_pc <= '0;
         r_perf   <= '0;
      end else begin
         if (|w_stall && r_perf != '1) r_perf <= r_perf + 1'b1;
         if (excp_valid) begin
            r_state  <= FLUSH;
            r_flush  <= 1'b1;
            r_new_pc <= excp_handler;
            r_cnt    <= '0;
         end else begin
            r_flush <= 1'b0;
            case (r_state)
               IDLE: if (ex_mc_start && ex_mc_len != '0) begin
                  r_cnt   <= ex_mc_len;
                  r_state <= MULTI;
               end
               MULTI: if (r_cnt > MC_CNT_W'(1)) r_cnt <= r_cnt - 1'b1;
               else begin
                  r_cnt   <= '0;
                  r_state <= IDLE;
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end
   assign stall          = w_stall;
   assign ex_mc_done     = w_done;
   assign flush          = r_flush;
   assign new_pc         = r_new_pc;
   assign ex_mc_busy     = r_state == MULTI;
   assign perf_stall_cnt = r_perf;
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: scoreboard bench for pipe_ctrl with a cycle-level behavioural model.
module tb_pipe_ctrl;
   logic        clk = 1'b0;
   logic        rst, stallreq_id, stallreq_ex, ex_mc_start, excp_valid;
   logic [5:0]  ex_mc_len;
   logic [31:0] excp_handler;
   logic [5:0]  stall, stall3;
   logic        flush, flush3, busy, busy3, done, done3;
   logic [31:0] new_pc, new_pc3;
   logic [15:0] perf;
   logic [2:0]  perf3;
   int checks = 0, errors = 0;

   typedef struct {
      logic [5:0]  stall;
      logic        done, flush, busy;
      logic [31:0] pc;
      int          perf;
   } exp_t;
   exp_t sb[$];

   // model state: cycles left until the done pulse, pending flush, redirect pc, total stalled cycles
   int          m_left = 0, m_perf = 0;
   logic        m_flush = 1'b0;
   logic [31:0] m_pc = '0;

   always #5 clk = ~clk;

   pipe_ctrl dut (
      .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex),
      .ex_mc_start(ex_mc_start), .ex_mc_len(ex_mc_len), .excp_valid(excp_valid),
      .excp_handler(excp_handler), .stall(stall), .flush(flush), .new_pc(new_pc),
      .ex_mc_busy(busy), .ex_mc_done(done), .perf_stall_cnt(perf)
   );
   pipe_ctrl #(.PERF_W(3)) dut3 (
      .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex),
      .ex_mc_start(ex_mc_start), .ex_mc_len(ex_mc_len), .excp_valid(excp_valid),
      .excp_handler(excp_handler), .stall(stall3), .flush(flush3), .new_pc(new_pc3),
      .ex_mc_busy(busy3), .ex_mc_done(done3), .perf_stall_cnt(perf3)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   task automatic cyc(input logic r, id, ex, st, input logic [5:0] len,
                      input logic ev, input logic [31:0] h);
      exp_t e;
      @(posedge clk);
      #1;
      rst = r; stallreq_id = id; stallreq_ex = ex; ex_mc_start = st;
      ex_mc_len = len; excp_valid = ev; excp_handler = h;
      e.flush = m_flush; e.pc = m_pc; e.busy = m_left > 0; e.perf = m_perf;
      e.stall = '0; e.done = 1'b0;
      if (r) begin
         m_flush = 1'b0; m_pc = '0; m_left = 0; m_perf = 0;
      end else begin
         if (ev) begin
            m_flush = 1'b1; m_pc = h; m_left = 0;
         end else if (m_flush) m_flush = 1'b0;
         else if (m_left > 1) begin
            e.stall = 6'h0F; m_left--;
         end else if (m_left == 0 && st) begin
            if (len != 0) begin
               e.stall = 6'h0F; m_left = len;
            end else e.done = 1'b1;
         end else begin
            e.done  = m_left == 1;
            e.stall = ex ? 6'h0F : id ? 6'h07 : 6'h00;
            m_left  = 0;
         end
         if (e.stall != 0) m_perf++;
      end
      sb.push_back(e);
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(0, 0, 0, 0, 0, 0, 0);
   endtask

   // monitor: every cycle the DUT presents a full output set, checked mid-cycle
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         chk("stall", 32'(stall), 32'(e.stall));
         chk("done", 32'(done), 32'(e.done));
         chk("flush", 32'(flush), 32'(e.flush));
         chk("new_pc", new_pc, e.pc);
         chk("busy", 32'(busy), 32'(e.busy));
         chk("perf16", 32'(perf), e.perf > 65535 ? 32'd65535 : 32'(e.perf));
         chk("perf3", 32'(perf3), e.perf > 7 ? 32'd7 : 32'(e.perf));
         chk("stall_w3", 32'(stall3), 32'(e.stall));
      end
   end

   initial begin
      rst = 1'b1; stallreq_id = 0; stallreq_ex = 0; ex_mc_start = 0;
      ex_mc_len = 0; excp_valid = 0; excp_handler = 0;
      repeat (2) @(posedge clk);
      repeat (2) cyc(1, 0, 1, 0, 0, 0, 0);
      repeat (2) cyc(0, 1, 0, 0, 0, 0, 0);
      repeat (2) cyc(0, 1, 1, 0, 0, 0, 0);
      idle(1);
      cyc(0, 0, 0, 1, 4, 0, 0);
      idle(5);
      cyc(0, 0, 1, 1, 0, 0, 0);
      idle(1);
      cyc(0, 1, 0, 1, 2, 0, 0);
      repeat (3) cyc(0, 1, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 10, 0, 0);
      idle(2);
      cyc(0, 0, 0, 0, 0, 1, 32'hBFC00380);
      idle(12);
      cyc(0, 0, 1, 0, 0, 1, 32'h1111_2222);
      cyc(0, 0, 1, 0, 0, 1, 32'h3333_4444);
      cyc(0, 0, 1, 0, 0, 0, 0);
      idle(1);
      cyc(1, 0, 0, 0, 0, 0, 0);
      repeat (9) cyc(0, 1, 0, 0, 0, 0, 0);
      idle(1);
      cyc(0, 0, 0, 1, 8, 0, 0);
      idle(3);
      cyc(1, 0, 0, 0, 0, 0, 0);
      idle(10);
      for (int i = 0; i < 3000; i++)
         cyc($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
             $urandom_range(0, 7) == 0, 6'($urandom_range(0, 12)), $urandom_range(0, 24) == 0,
             $urandom);
      idle(2);
      repeat (2) @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d entries left, expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
